// File: rtl/scr1_tb_ahb_pkg.sv
// Shared encodings for the SCR1 testbench AHB-Lite data-memory slave.
// Contents: htrans/hsize codes, slave FSM state type, byte-lane enable helper.
package scr1_tb_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} type_scr1_tb_ahb_state_e;

  // Lane enables for a (legal) transfer of the given size at byte offset a.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return 4'b0011 << a;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/scr1_tb_stall_gen.sv
// Rotating wait-state pattern for the data-memory slave.
//  clk           in  clock
//  reload        in  asynchronous load of pattern (held high during reset)
//  stall_pattern in  32-bit pattern; all-zero loads all-ones so the bus can never hang
//  advance       in  rotate right by one bit
//  ready_bit     out current pattern bit 0 (1 = ready cycle)
module scr1_tb_stall_gen (
  input  logic        clk,
  input  logic        reload,
  input  logic [31:0] stall_pattern,
  input  logic        advance,
  output logic        ready_bit
);

  logic [31:0] pat;

  // Pattern is sampled for as long as reload is held, not just on its edge.
  always_ff @(posedge clk or posedge reload) begin
    if (reload)       pat <= (stall_pattern == 32'h0) ? 32'hFFFF_FFFF : stall_pattern;
    else if (advance) pat <= {pat[0], pat[31:1]};
  end

  assign ready_bit = pat[0];

endmodule

// File: rtl/scr1_tb_ahb_dmem_slave.sv
// AHB-Lite data-memory slave model used by the SCR1 AHB top testbench.
// Word-organised memory with byte-lane writes, wait states from a rotating
// stall pattern, and a two-cycle ERROR response for illegal transfers.
//  clk, rst                      clock, asynchronous active-high reset
//  stall_pattern                 wait-state pattern (bit=1 -> ready), loaded in reset
//  hsize, htrans, haddr, hwrite  address phase
//  hwdata                        write data (data phase)
//  hready, hrdata, hresp         slave response
module scr1_tb_ahb_dmem_slave
  import scr1_tb_ahb_pkg::*;
#(
  parameter int MEM_POWER_SIZE = 16,
  parameter int AHB_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          stall_pattern,
  input  logic [2:0]           hsize,
  input  logic [1:0]           htrans,
  input  logic [AHB_WIDTH-1:0] haddr,
  input  logic                 hwrite,
  input  logic [AHB_WIDTH-1:0] hwdata,
  output logic                 hready,
  output logic [AHB_WIDTH-1:0] hrdata,
  output logic                 hresp
);

  localparam int MEM_WORDS = 2 ** (MEM_POWER_SIZE - 2);

  type_scr1_tb_ahb_state_e   state;
  logic [MEM_POWER_SIZE-3:0] word_q;
  logic [3:0]                be_q;
  logic                      write_q;

  logic [AHB_WIDTH-1:0]      mem [MEM_WORDS];

  logic ready_bit;
  logic accept;
  logic aligned;
  logic legal;
  logic mem_we;
  logic unused_bits;

  // htrans[0] only distinguishes SEQ from NONSEQ, which this slave treats alike.
  assign unused_bits = htrans[0];

  scr1_tb_stall_gen u_stall (
    .clk           (clk),
    .reload        (rst),
    .stall_pattern (stall_pattern),
    .advance       (state == DATA),
    .ready_bit     (ready_bit)
  );

  always_comb begin
    case (hsize)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~haddr[0];
      HSIZE_WORD: aligned = (haddr[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  // Out-of-range addresses are rejected, never wrapped onto the array.
  assign legal  = aligned && (haddr[AHB_WIDTH-1:MEM_POWER_SIZE] == '0);
  assign accept = hready && htrans[1];
  assign mem_we = (state == DATA) && ready_bit && write_q;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state)
      DATA: begin
        hready = ready_bit;
        if (ready_bit && !write_q) hrdata = mem[word_q];
      end
      ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ERR2:    hresp = 1'b1;
      default: ;
    endcase
  end

  // Whenever hready is high the current phase ends and the bus may start a
  // new one; this covers IDLE, ERR2 and a completing DATA cycle uniformly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      if (state == ERR1) begin
        state <= ERR2;
      end else if (hready) begin
        if (accept) state <= legal ? DATA : ERR1;
        else        state <= IDLE;
      end
      if (accept && legal) begin
        word_q  <= haddr[MEM_POWER_SIZE-1:2];
        be_q    <= ahb_byte_en(hsize, haddr[1:0]);
        write_q <= hwrite;
      end
    end
  end

  // Memory is intentionally not reset; a write held in wait states when rst
  // rises is dropped because the state leaves DATA asynchronously.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[word_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule
